ad_ip_jesd204_tpl_dac_hop_sched: RTL and testbench

- Frequency-hopping scheduler for the DDS tones of one TPL DAC channel.
- Holds a small table of (tone-0 increment, tone-1 increment, dwell) entries loaded through a config write port.
- On start, steps through the table gaplessly and drives the channel's dac_dds_incr_0/1.
- Pulses dac_data_sync on every hop so the DDS phase restarts from its init offset.

---
 rtl/ad_ip_jesd204_tpl_dac_pkg.sv | 14 +
 rtl/ad_ip_jesd204_tpl_dac_hop_table.sv | 64 ++++++
 rtl/ad_ip_jesd204_tpl_dac_hop_sched.sv | 143 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_hop_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared definitions for the TPL DAC hop scheduler: FSM state encoding and entry field widths.
package ad_ip_jesd204_tpl_dac_pkg;

    localparam int INCR_W = 16;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DWELL = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        DWELL = ST_DWELL
    } hop_state_t;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_hop_table.sv
// Hop table register file: one write port, one combinational read port.
// Every entry clears on reset.
module ad_ip_jesd204_tpl_dac_hop_table
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int DWELL_WIDTH = 24,
    parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [INCR_W-1:0]      wr_incr_0,
    input  logic [INCR_W-1:0]      wr_incr_1,
    input  logic [DWELL_WIDTH-1:0] wr_dwell,
    input  logic                   wr_last,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [INCR_W-1:0]      rd_incr_0,
    output logic [INCR_W-1:0]      rd_incr_1,
    output logic [DWELL_WIDTH-1:0] rd_dwell,
    output logic                   rd_last
);

    logic [INCR_W-1:0]      incr_0_arr [NUM_ENTRIES];
    logic [INCR_W-1:0]      incr_1_arr [NUM_ENTRIES];
    logic [DWELL_WIDTH-1:0] dwell_arr  [NUM_ENTRIES];
    logic                   last_arr   [NUM_ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            logic [INCR_W-1:0]      incr_0_reg;
            logic [INCR_W-1:0]      incr_1_reg;
            logic [DWELL_WIDTH-1:0] dwell_reg;
            logic                   last_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    incr_0_reg <= '0;
                    incr_1_reg <= '0;
                    dwell_reg  <= '0;
                    last_reg   <= 1'b0;
                end else if (wr && (wr_addr == ADDR_WIDTH'(gi))) begin
                    incr_0_reg <= wr_incr_0;
                    incr_1_reg <= wr_incr_1;
                    dwell_reg  <= wr_dwell;
                    last_reg   <= wr_last;
                end
            end

            assign incr_0_arr[gi] = incr_0_reg;
            assign incr_1_arr[gi] = incr_1_reg;
            assign dwell_arr[gi]  = dwell_reg;
            assign last_arr[gi]   = last_reg;
        end
    endgenerate

    assign rd_incr_0 = incr_0_arr[rd_addr];
    assign rd_incr_1 = incr_1_arr[rd_addr];
    assign rd_dwell  = dwell_arr[rd_addr];
    assign rd_last   = last_arr[rd_addr];

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_hop_sched.sv
// Frequency-hopping scheduler: steps through the hop table, driving the DDS increments
// of one DAC channel and pulsing dac_data_sync on every load.
module ad_ip_jesd204_tpl_dac_hop_sched
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int DWELL_WIDTH = 24,
    parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_wr,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [INCR_W-1:0]      cfg_incr_0,
    input  logic [INCR_W-1:0]      cfg_incr_1,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_last,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    output logic [INCR_W-1:0]      dac_dds_incr_0,
    output logic [INCR_W-1:0]      dac_dds_incr_1,
    output logic                   dac_data_sync,
    output logic                   busy,
    output logic [ADDR_WIDTH-1:0]  cur_index,
    output logic                   done
);

    hop_state_t             state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  idx_reg, idx_next;
    logic [DWELL_WIDTH-1:0] cnt_reg, cnt_next;
    logic [INCR_W-1:0]      incr_0_reg, incr_0_next;
    logic [INCR_W-1:0]      incr_1_reg, incr_1_next;
    logic                   last_reg, last_next;
    logic                   sync_reg, sync_next;
    logic                   done_reg, done_next;
    logic                   start_reg, start_next;

    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [INCR_W-1:0]      rd_incr_0;
    logic [INCR_W-1:0]      rd_incr_1;
    logic [DWELL_WIDTH-1:0] rd_dwell;
    logic                   rd_last;
    logic                   at_last;

    ad_ip_jesd204_tpl_dac_hop_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .DWELL_WIDTH (DWELL_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) i_table (
        .clk       (clk),
        .reset     (reset),
        .wr        (cfg_wr),
        .wr_addr   (cfg_addr),
        .wr_incr_0 (cfg_incr_0),
        .wr_incr_1 (cfg_incr_1),
        .wr_dwell  (cfg_dwell),
        .wr_last   (cfg_last),
        .rd_addr   (rd_addr),
        .rd_incr_0 (rd_incr_0),
        .rd_incr_1 (rd_incr_1),
        .rd_dwell  (rd_dwell),
        .rd_last   (rd_last)
    );

    // The last flag is latched at load, so rewriting the playing entry cannot change its fate.
    assign at_last = last_reg || (idx_reg == ADDR_WIDTH'(NUM_ENTRIES - 1));
    assign rd_addr = ((state_reg == DWELL) && !at_last) ? idx_reg + ADDR_WIDTH'(1) : '0;

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        incr_0_next = incr_0_reg;
        incr_1_next = incr_1_reg;
        last_next   = last_reg;
        sync_next   = 1'b0;
        done_next   = 1'b0;
        start_next  = start && !stop && (state_reg == IDLE);

        case (state_reg)
            IDLE: begin
                if (start_reg && !stop) begin
                    state_next = DWELL;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DWELL_WIDTH'(1);
                end else if (at_last && !loop_en) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A load happens on a start from idle or any hop that continues the sequence.
        if ((state_reg == IDLE && start_reg && !stop) ||
            (state_reg == DWELL && !stop && cnt_reg == '0 && (!at_last || loop_en))) begin
            idx_next    = rd_addr;
            incr_0_next = rd_incr_0;
            incr_1_next = rd_incr_1;
            last_next   = rd_last;
            cnt_next    = (rd_dwell == '0) ? '0 : rd_dwell - DWELL_WIDTH'(1);
            sync_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            incr_0_reg <= '0;
            incr_1_reg <= '0;
            last_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            done_reg   <= 1'b0;
            start_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            incr_0_reg <= incr_0_next;
            incr_1_reg <= incr_1_next;
            last_reg   <= last_next;
            sync_reg   <= sync_next;
            done_reg   <= done_next;
            start_reg  <= start_next;
        end
    end

    assign dac_dds_incr_0 = incr_0_reg;
    assign dac_dds_incr_1 = incr_1_reg;
    assign dac_data_sync  = sync_reg;
    assign busy           = (state_reg == DWELL);
    assign cur_index      = idx_reg;
    assign done           = done_reg;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_hop_sched.sv
// Directed bench for the hop scheduler: basic, loop with live rewrite, stop, dwell 0, async reset.
module tb_ad_ip_jesd204_tpl_dac_hop_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_incr_0;
    logic [15:0] cfg_incr_1;
    logic [23:0] cfg_dwell;
    logic        cfg_last;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [15:0] dac_dds_incr_0;
    logic [15:0] dac_dds_incr_1;
    logic        dac_data_sync;
    logic        busy;
    logic [2:0]  cur_index;
    logic        done;

    int total = 0;
    int bad   = 0;

    ad_ip_jesd204_tpl_dac_hop_sched #(
        .NUM_ENTRIES (8),
        .DWELL_WIDTH (24)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr         (cfg_wr),
        .cfg_addr       (cfg_addr),
        .cfg_incr_0     (cfg_incr_0),
        .cfg_incr_1     (cfg_incr_1),
        .cfg_dwell      (cfg_dwell),
        .cfg_last       (cfg_last),
        .start          (start),
        .stop           (stop),
        .loop_en        (loop_en),
        .dac_dds_incr_0 (dac_dds_incr_0),
        .dac_dds_incr_1 (dac_dds_incr_1),
        .dac_data_sync  (dac_data_sync),
        .busy           (busy),
        .cur_index      (cur_index),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] i0, input logic [15:0] i1,
                           input logic sync, input logic bsy, input logic [2:0] idx,
                           input logic dn);
        chk({tag, ".incr0"}, 32'(dac_dds_incr_0), 32'(i0));
        chk({tag, ".incr1"}, 32'(dac_dds_incr_1), 32'(i1));
        chk({tag, ".sync"},  32'(dac_data_sync),  32'(sync));
        chk({tag, ".busy"},  32'(busy),           32'(bsy));
        chk({tag, ".idx"},   32'(cur_index),      32'(idx));
        chk({tag, ".done"},  32'(done),           32'(dn));
        $display("%s: incr=%h/%h sync=%0b busy=%0b idx=%0d done=%0b", tag,
                 dac_dds_incr_0, dac_dds_incr_1, dac_data_sync, busy, cur_index, done);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] i0, input logic [15:0] i1,
                      input logic [23:0] dw, input logic lst);
        cfg_wr     = 1'b1;
        cfg_addr   = a;
        cfg_incr_0 = i0;
        cfg_incr_1 = i1;
        cfg_dwell  = dw;
        cfg_last   = lst;
        tick();
        cfg_wr     = 1'b0;
    endtask

    initial begin
        int e;
        reset      = 1'b1;
        cfg_wr     = 1'b0;
        cfg_addr   = '0;
        cfg_incr_0 = '0;
        cfg_incr_1 = '0;
        cfg_dwell  = '0;
        cfg_last   = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        loop_en    = 1'b0;
        repeat (2) tick();
        chk_out("reset", 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;

        // Basic two-entry sequence
        wr(3'd0, 16'h1000, 16'h2000, 24'd4, 1'b0);
        wr(3'd1, 16'h3000, 16'h4000, 24'd3, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("basic.c1", 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        for (int c = 2; c <= 10; c++) begin
            string t;
            t = $sformatf("basic.c%0d", c);
            if (c <= 5)
                chk_out(t, 16'h1000, 16'h2000, c == 2, 1'b1, 3'd0, 1'b0);
            else if (c <= 8)
                chk_out(t, 16'h3000, 16'h4000, c == 6, 1'b1, 3'd1, 1'b0);
            else
                chk_out(t, 16'h3000, 16'h4000, 1'b0, 1'b0, 3'd1, c == 9);
            tick();
        end

        // Loop mode with a live rewrite of entry 0 during its first play
        loop_en = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int c = 2; c <= 18; c++) begin
            string t;
            t = $sformatf("loop.c%0d", c);
            e = (c - 2) % 7;
            if (e < 4)
                chk_out(t, (c < 9) ? 16'h1000 : 16'h5555, 16'h2000, e == 0, 1'b1, 3'd0, 1'b0);
            else
                chk_out(t, 16'h3000, 16'h4000, e == 4, 1'b1, 3'd1, 1'b0);
            if (c == 3) begin
                cfg_wr     = 1'b1;
                cfg_addr   = 3'd0;
                cfg_incr_0 = 16'h5555;
                cfg_incr_1 = 16'h2000;
                cfg_dwell  = 24'd4;
                cfg_last   = 1'b0;
            end
            if (c == 18) stop = 1'b1;
            tick();
            cfg_wr = 1'b0;
        end
        stop    = 1'b0;
        loop_en = 1'b0;
        chk_out("loop.stopped", 16'h5555, 16'h2000, 1'b0, 1'b0, 3'd0, 1'b0);

        // Stop in the second cycle of entry 0, then start+stop together
        wr(3'd0, 16'h1000, 16'h2000, 24'd4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_out("stop.c2", 16'h1000, 16'h2000, 1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("stop.c3", 16'h1000, 16'h2000, 1'b0, 1'b1, 3'd0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("stop.c4", 16'h1000, 16'h2000, 1'b0, 1'b0, 3'd0, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_out($sformatf("startstop.%0d", c), 16'h1000, 16'h2000, 1'b0, 1'b0, 3'd0, 1'b0);
            tick();
        end

        // Dwell 0 on every entry, no last bits: implicit last at index 7
        for (int k = 0; k < 8; k++)
            wr(3'(k), 16'(k * 256 + 1), 16'(16'hA000 + k), 24'd0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int c = 2; c <= 10; c++) begin
            string t;
            t = $sformatf("dw0.c%0d", c);
            if (c <= 9)
                chk_out(t, 16'((c - 2) * 256 + 1), 16'(16'hA000 + c - 2), 1'b1, 1'b1, 3'(c - 2), 1'b0);
            else
                chk_out(t, 16'h0701, 16'hA007, 1'b0, 1'b0, 3'd7, 1'b1);
            tick();
        end

        // Asynchronous reset in the middle of a long dwell
        wr(3'd0, 16'h1234, 16'h5678, 24'd5, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_out("arst.c2", 16'h1234, 16'h5678, 1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        #3 reset = 1'b1;
        #1 chk_out("arst.in", 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        #2 reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int c = 2; c <= 10; c++) begin
            string t;
            t = $sformatf("zero.c%0d", c);
            if (c <= 9)
                chk_out(t, 16'h0, 16'h0, 1'b1, 1'b1, 3'(c - 2), 1'b0);
            else
                chk_out(t, 16'h0, 16'h0, 1'b0, 1'b0, 3'd7, 1'b1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
